fetch_unit: RTL and testbench

- Instruction fetch stage of the HOLY CORE.
- Owns the architectural PC and issues one instruction-memory request at a time over a valid/ready handshake.
- Holds the returned instruction stable for the decode/control stage.
- On each instruction commit, selects the next PC from the control unit's pc_source. It also flags instruction-address-misaligned and access-fault exceptions, and counts retired instructions.

---
 rtl/fetch_unit.sv | 133 +++++++++++++
 tb/tb_fetch_unit.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// HOLY CORE instruction fetch stage: owns the PC, runs a one-outstanding imem handshake, holds the instruction for decode.
// Optional same-cycle response bypass to decode is enabled with `define FETCH_BYPASS_EN.
package fetch_unit_pkg;
   typedef enum logic [1:0] {
      SOURCE_PC_PLUS_4     = 2'd0,
      SOURCE_PC_SECOND_ADD = 2'd1,
      SOURCE_PC_MTVEC      = 2'd2
   } pc_source_t;
endpackage

module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR    = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst_n,
   input  pc_source_t  pc_source,
   input  logic        m_ret,
   input  logic [31:0] second_add_result,
   input  logic [31:0] mtvec,
   input  logic [31:0] mepc,
   input  logic        stall_ext,
   output logic        imem_req_valid,
   output logic [31:0] imem_req_addr,
   input  logic        imem_req_ready,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   input  logic        imem_rsp_error,
   output logic [31:0] pc,
   output logic [31:0] pc_plus_four,
   output logic [31:0] instr,
   output logic        instr_valid,
   output logic        fetch_stall,
   output logic        fetch_exception,
   output logic [30:0] fetch_exception_cause,
   output logic [63:0] instret
);
   // Handshake: a request transfers on a cycle with imem_req_valid && imem_req_ready;
   // imem_req_addr is held while valid && ~ready. Responses are one-cycle pulses only honoured in S_WAIT.
   typedef enum logic [1:0] {S_REQ = 2'd0, S_WAIT = 2'd1, S_VALID = 2'd2} state_t;

   state_t      r_state;
   logic [31:0] r_pc;
   logic [31:0] r_instr;
   logic        r_exc;
   logic [30:0] r_cause;
   logic [63:0] r_instret;

   logic        w_rsp_take;
   logic        w_bypass;
   logic [31:0] w_rsp_instr;
   logic        w_commit;
   logic [31:0] w_next_pc;
   logic        w_misaligned;

   assign w_rsp_take  = (r_state == S_WAIT) && imem_rsp_valid;
   assign w_rsp_instr = imem_rsp_error ? NOP_INSTR : imem_rsp_data;
`ifdef FETCH_BYPASS_EN
   assign w_bypass = w_rsp_take;
`else
   assign w_bypass = 1'b0;
`endif

   assign imem_req_valid        = (r_state == S_REQ);
   assign imem_req_addr         = r_pc;
   assign pc                    = r_pc;
   assign pc_plus_four          = r_pc + 32'd4;
   assign instr_valid           = (r_state == S_VALID) || w_bypass;
   assign fetch_stall           = ~instr_valid;
   assign instr                 = w_bypass ? w_rsp_instr : r_instr;
   assign fetch_exception       = w_bypass ? imem_rsp_error : r_exc;
   assign fetch_exception_cause = w_bypass ? {30'd0, imem_rsp_error} : r_cause;
   assign instret               = r_instret;
   assign w_commit              = instr_valid && !stall_ext;

   // MTVEC outranks MRET so a trap taken on an MRET still lands in the handler.
   always_comb begin
      w_next_pc = r_pc + 32'd4;
      if (pc_source == SOURCE_PC_MTVEC)
         w_next_pc = {mtvec[31:2], 2'b00};
      else if (m_ret)
         w_next_pc = mepc;
      else if (pc_source == SOURCE_PC_SECOND_ADD)
         w_next_pc = second_add_result;
   end

   assign w_misaligned = (w_next_pc[1:0] != 2'b00) && (pc_source != SOURCE_PC_MTVEC);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state   <= S_REQ;
         r_pc      <= RESET_VECTOR;
         r_instr   <= NOP_INSTR;
         r_exc     <= 1'b0;
         r_cause   <= 31'd0;
         r_instret <= 64'd0;
      end else if (w_commit) begin
         r_pc <= w_next_pc;
         if (!fetch_exception)
            r_instret <= r_instret + 64'd1;
         if (w_misaligned) begin
            // Never fetch from a misaligned target; present a faulting NOP instead.
            r_state <= S_VALID;
            r_instr <= NOP_INSTR;
            r_exc   <= 1'b1;
            r_cause <= 31'd0;
         end else begin
            r_state <= S_REQ;
            r_exc   <= 1'b0;
            r_cause <= 31'd0;
         end
      end else begin
         case (r_state)
            S_REQ: begin
               if (imem_req_ready)
                  r_state <= S_WAIT;
            end
            S_WAIT: begin
               if (imem_rsp_valid) begin
                  r_instr <= w_rsp_instr;
                  r_exc   <= imem_rsp_error;
                  r_cause <= {30'd0, imem_rsp_error};
                  r_state <= S_VALID;
               end
            end
            S_VALID: ;
            default: r_state <= S_REQ;
         endcase
      end
   end
endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit with hand-computed PCs, instructions and retire counts.
module tb_fetch_unit;
   import fetch_unit_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   pc_source_t  pc_source;
   logic        m_ret;
   logic [31:0] second_add_result;
   logic [31:0] mtvec;
   logic [31:0] mepc;
   logic        stall_ext;
   logic        imem_req_valid;
   logic [31:0] imem_req_addr;
   logic        imem_req_ready;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        imem_rsp_error;
   logic [31:0] pc;
   logic [31:0] pc_plus_four;
   logic [31:0] instr;
   logic        instr_valid;
   logic        fetch_stall;
   logic        fetch_exception;
   logic [30:0] fetch_exception_cause;
   logic [63:0] instret;

   int n_cmp = 0;
   int n_mis = 0;
   logic [63:0] exp_ret;

`ifdef FETCH_BYPASS_EN
   localparam int EXP_COMMITS = 6;
`else
   localparam int EXP_COMMITS = 4;
`endif

   fetch_unit #(.RESET_VECTOR(32'h0000_0100), .NOP_INSTR(32'h0000_0013)) dut (
      .clk(clk), .rst_n(rst_n), .pc_source(pc_source), .m_ret(m_ret),
      .second_add_result(second_add_result), .mtvec(mtvec), .mepc(mepc),
      .stall_ext(stall_ext), .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
      .imem_req_ready(imem_req_ready), .imem_rsp_valid(imem_rsp_valid),
      .imem_rsp_data(imem_rsp_data), .imem_rsp_error(imem_rsp_error),
      .pc(pc), .pc_plus_four(pc_plus_four), .instr(instr), .instr_valid(instr_valid),
      .fetch_stall(fetch_stall), .fetch_exception(fetch_exception),
      .fetch_exception_cause(fetch_exception_cause), .instret(instret)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Starts in S_REQ with stall_ext high; returns at negedge+1 with the instruction held.
   task automatic do_fetch(input logic [31:0] data, input logic err);
      @(negedge clk);
      imem_req_ready = 1'b1;
      @(negedge clk);
      imem_req_ready = 1'b0;
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = data;
      imem_rsp_error = err;
      @(negedge clk);
      imem_rsp_valid = 1'b0;
      imem_rsp_error = 1'b0;
      #1;
   endtask

   task automatic do_commit(input pc_source_t src, input logic [31:0] sa, input logic mr);
      @(negedge clk);
      pc_source         = src;
      second_add_result = sa;
      m_ret             = mr;
      stall_ext         = 1'b0;
      @(negedge clk);
      stall_ext = 1'b1;
      m_ret     = 1'b0;
      pc_source = SOURCE_PC_PLUS_4;
      #1;
   endtask

   initial begin
      int commits;
      logic pending;
      rst_n = 1'b0; pc_source = SOURCE_PC_PLUS_4; m_ret = 1'b0;
      second_add_result = 32'h0; mtvec = 32'h81; mepc = 32'h300; stall_ext = 1'b1;
      imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0; imem_rsp_error = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      #1;
      check_eq("rst_req_valid", imem_req_valid, 1);
      check_eq("rst_addr", imem_req_addr, 32'h100);
      check_eq("rst_instr_valid", instr_valid, 0);
      check_eq("rst_fetch_stall", fetch_stall, 1);
      check_eq("rst_instr", instr, 32'h13);
      check_eq("rst_exc", fetch_exception, 0);
      check_eq("rst_instret", instret, 0);

      do_fetch(32'h0050_0093, 1'b0);
      check_eq("f1_valid", instr_valid, 1);
      check_eq("f1_instr", instr, 32'h0050_0093);
      check_eq("f1_pc", pc, 32'h100);
      check_eq("f1_pc4", pc_plus_four, 32'h104);
      check_eq("f1_stall", fetch_stall, 0);
      do_commit(SOURCE_PC_PLUS_4, 32'h0, 1'b0);
      check_eq("plus4_addr", imem_req_addr, 32'h104);
      check_eq("plus4_req", imem_req_valid, 1);
      check_eq("plus4_instret", instret, 1);

      do_fetch(32'h0000_0073, 1'b0);
      do_commit(SOURCE_PC_SECOND_ADD, 32'h200, 1'b1);
      check_eq("mret_addr", imem_req_addr, 32'h300);
      do_fetch(32'h0000_0063, 1'b0);
      do_commit(SOURCE_PC_SECOND_ADD, 32'h200, 1'b0);
      check_eq("sa_addr", imem_req_addr, 32'h200);
      do_fetch(32'h0000_0063, 1'b0);
      do_commit(SOURCE_PC_MTVEC, 32'h200, 1'b1);
      check_eq("mtvec_addr", imem_req_addr, 32'h80);
      check_eq("instret4", instret, 4);

      do_fetch(32'h0000_006F, 1'b0);
      do_commit(SOURCE_PC_SECOND_ADD, 32'h202, 1'b0);
      check_eq("mis_req", imem_req_valid, 0);
      check_eq("mis_valid", instr_valid, 1);
      check_eq("mis_instr", instr, 32'h13);
      check_eq("mis_exc", fetch_exception, 1);
      check_eq("mis_cause", fetch_exception_cause, 0);
      check_eq("mis_pc", pc, 32'h202);
      check_eq("mis_instret", instret, 5);
      mtvec = 32'h80;
      do_commit(SOURCE_PC_MTVEC, 32'h0, 1'b0);
      check_eq("trap_addr", imem_req_addr, 32'h80);
      check_eq("trap_instret", instret, 5);

      // Stray response in S_REQ plus ready held low for five cycles.
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         imem_rsp_valid = (i == 2);
         imem_rsp_data  = 32'hDEAD_BEEF;
         #1;
         check_eq("hold_addr", imem_req_addr, 32'h80);
         check_eq("hold_stall", fetch_stall, 1);
      end
      @(negedge clk);
      imem_rsp_valid = 1'b0;
      #1;
      check_eq("hold_req", imem_req_valid, 1);
      do_fetch(32'h1234_5678, 1'b1);
      check_eq("err_instr", instr, 32'h13);
      check_eq("err_exc", fetch_exception, 1);
      check_eq("err_cause", fetch_exception_cause, 1);
      check_eq("err_stall", fetch_stall, 0);
      do_commit(SOURCE_PC_PLUS_4, 32'h0, 1'b0);
      check_eq("err_addr", imem_req_addr, 32'h84);
      check_eq("err_instret", instret, 5);

      do_fetch(32'h0010_0073, 1'b0);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         imem_rsp_valid = (i == 1);
         imem_rsp_data  = 32'hDEAD_BEEF;
         #1;
         check_eq("stall_pc", pc, 32'h84);
         check_eq("stall_instr", instr, 32'h0010_0073);
         check_eq("stall_req", imem_req_valid, 0);
         check_eq("stall_instret", instret, 5);
      end
      imem_rsp_valid = 1'b0;
      do_commit(SOURCE_PC_PLUS_4, 32'h0, 1'b0);
      check_eq("stall_addr", imem_req_addr, 32'h88);
      check_eq("stall_instret_after", instret, 6);
      exp_ret = 64'd6;

      // Back-to-back memory: ready always high, response the cycle after acceptance.
      commits = 0;
      pending = 1'b0;
      stall_ext = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         imem_req_ready = 1'b1;
         imem_rsp_valid = pending;
         imem_rsp_data  = 32'h0000_0013;
         #1;
         if (instr_valid) commits++;
         pending = imem_req_valid;
      end
      @(negedge clk);
      stall_ext = 1'b1;
      imem_req_ready = 1'b0;
      imem_rsp_valid = 1'b0;
      #1;
      exp_ret = exp_ret + EXP_COMMITS;
      check_eq("tput_commits", commits, EXP_COMMITS);
      check_eq("tput_instret", instret, exp_ret);
      check_eq("tput_addr", imem_req_addr, 32'h88 + 4 * EXP_COMMITS);

      do_fetch(32'h0000_006F, 1'b0);
      do_commit(SOURCE_PC_SECOND_ADD, 32'hFFFF_FFFC, 1'b0);
      check_eq("top_addr", imem_req_addr, 32'hFFFF_FFFC);
      do_fetch(32'h0000_0013, 1'b0);
      check_eq("top_pc4", pc_plus_four, 32'h0);
      do_commit(SOURCE_PC_PLUS_4, 32'h0, 1'b0);
      exp_ret = exp_ret + 2;
      check_eq("wrap_addr", imem_req_addr, 32'h0);
      check_eq("wrap_instret", instret, exp_ret);

      // Reset while a request is outstanding.
      @(negedge clk);
      imem_req_ready = 1'b1;
      @(negedge clk);
      imem_req_ready = 1'b0;
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check_eq("rst2_req", imem_req_valid, 1);
      check_eq("rst2_addr", imem_req_addr, 32'h100);
      check_eq("rst2_instret", instret, 0);
      check_eq("rst2_valid", instr_valid, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end
endmodule
